// File: rtl/elevator_shaft_model.sv
// Plant model of a 4-floor car and shaft. It turns controller motor/door commands into
// floor sensors, door status and a sticky fault code.
module elevator_shaft_model #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8,
  parameter int INIT_FLOOR    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor_up,
  input  logic       motor_down,
  input  logic       door_open,
  input  logic [3:0] sensor_mask,
  output logic [3:0] floor_sensor,
  output logic [1:0] car_floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_closed,
  output logic       door_fully_open,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int POS_MAX = 3 * TRAVEL_CYCLES;
  localparam int POS_W   = $clog2(POS_MAX + 1);
  localparam int DPOS_W  = $clog2(DOOR_CYCLES + 1);

  localparam logic [POS_W-1:0]  POS_TOP  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  POS_INIT = POS_W'(INIT_FLOOR * TRAVEL_CYCLES);
  localparam logic [POS_W-1:0]  TRAVEL   = POS_W'(TRAVEL_CYCLES);
  localparam logic [DPOS_W-1:0] DOOR_TOP = DPOS_W'(DOOR_CYCLES);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, FAULT} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DPOS_W-1:0]  dpos_q, dpos_d;
  logic [1:0]         code_q, code_d;
  logic               mu_q, mu_d;
  logic               md_q, md_d;
  logic               aligned;
  logic               any_motor;

  assign any_motor = motor_up | motor_down;
  assign aligned   = (pos_q % TRAVEL) == '0;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dpos_d  = dpos_q;
    code_d  = code_q;
    mu_d    = 1'b0;
    md_d    = 1'b0;

    // Violations are judged against the pre-edge door position, so a car that starts
    // moving on the same edge that a door command arrives does not fault.
    if (state_q != FAULT) begin
      if (motor_up && motor_down) begin
        state_d = FAULT;
        code_d  = 2'b01;
      end else if (any_motor && dpos_q != '0) begin
        state_d = FAULT;
        code_d  = 2'b10;
      end else if ((motor_up && pos_q == POS_TOP) || (motor_down && pos_q == '0)) begin
        state_d = FAULT;
        code_d  = 2'b11;
      end else if (motor_up) begin
        state_d = MOVE_UP;
        pos_d   = pos_q + POS_W'(1);
        mu_d    = 1'b1;
      end else if (motor_down) begin
        state_d = MOVE_DOWN;
        pos_d   = pos_q - POS_W'(1);
        md_d    = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    // The door keeps working in FAULT so passengers can be released.
    if (door_open) begin
      if (aligned && !any_motor && dpos_q < DOOR_TOP) dpos_d = dpos_q + DPOS_W'(1);
    end else if (dpos_q != '0) begin
      dpos_d = dpos_q - DPOS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= POS_INIT;
      dpos_q  <= '0;
      code_q  <= 2'b00;
      mu_q    <= 1'b0;
      md_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dpos_q  <= dpos_d;
      code_q  <= code_d;
      mu_q    <= mu_d;
      md_q    <= md_d;
    end
  end

  assign car_floor       = 2'(pos_q / TRAVEL);
  assign floor_sensor    = aligned ? ((4'b0001 << car_floor) & sensor_mask) : 4'b0000;
  assign moving_up       = mu_q;
  assign moving_down     = md_q;
  assign door_closed     = dpos_q == '0;
  assign door_fully_open = dpos_q == DOOR_TOP;
  assign fault           = state_q == FAULT;
  assign fault_code      = code_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for elevator_shaft_model: directed scenarios plus a randomized run against a
// position/door/fault reference model kept as plain integers.
module tb_elevator_shaft_model;

  localparam int TC = 16;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       motor_up = 1'b0;
  logic       motor_down = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] sensor_mask = 4'hF;
  logic [3:0] floor_sensor;
  logic [1:0] car_floor;
  logic       moving_up, moving_down, door_closed, door_fully_open, fault;
  logic [1:0] fault_code;

  int n_tests = 0;
  int n_fail  = 0;

  int m_pos, m_dpos, m_code;
  bit m_fault, m_mu, m_md;

  always #5 clk = ~clk;

  elevator_shaft_model #(
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC),
    .INIT_FLOOR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .door_open(door_open),
    .sensor_mask(sensor_mask),
    .floor_sensor(floor_sensor),
    .car_floor(car_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_closed(door_closed),
    .door_fully_open(door_fully_open),
    .fault(fault),
    .fault_code(fault_code)
  );

  // Reference: car position in steps, door position in steps, first fault code.
  function automatic void model_step(bit rst, bit up, bit dn, bit dop);
    int  old_pos  = m_pos;
    int  old_dpos = m_dpos;
    bit  at_floor = (old_pos % TC) == 0;
    if (rst) begin
      m_pos = 0; m_dpos = 0; m_code = 0; m_fault = 0; m_mu = 0; m_md = 0;
      return;
    end
    m_mu = 0;
    m_md = 0;
    if (!m_fault) begin
      if (up && dn) begin m_fault = 1; m_code = 1; end
      else if ((up || dn) && old_dpos != 0) begin m_fault = 1; m_code = 2; end
      else if ((up && old_pos == 3 * TC) || (dn && old_pos == 0)) begin m_fault = 1; m_code = 3; end
      else if (up) begin m_pos = old_pos + 1; m_mu = 1; end
      else if (dn) begin m_pos = old_pos - 1; m_md = 1; end
    end
    if (dop && at_floor && !up && !dn && old_dpos < DC) m_dpos = old_dpos + 1;
    else if (!dop && old_dpos > 0) m_dpos = old_dpos - 1;
  endfunction

  function automatic logic [13:0] expected_outputs();
    logic [3:0] sens = 4'b0000;
    logic [1:0] flr  = 2'(m_pos / TC);
    if (m_pos % TC == 0) sens = (4'b0001 << flr) & sensor_mask;
    return {sens, flr, m_mu, m_md, m_dpos == 0, m_dpos == DC, m_fault, 2'(m_code)};
  endfunction

  task automatic cycle(input bit rst, input bit up, input bit dn, input bit dop);
    reset = rst; motor_up = up; motor_down = dn; door_open = dop;
    @(posedge clk);
    model_step(rst, up, dn, dop);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input int n, input bit up, input bit dn, input bit dop);
    for (int i = 0; i < n; i++) cycle(1'b0, up, dn, dop);
  endtask

  task automatic test_reset();
    sensor_mask = 4'hF;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0001) begin n_fail++; $display("FAIL reset_sensor got %b want 0001", floor_sensor); end
    n_tests++; if (car_floor !== 2'd0) begin n_fail++; $display("FAIL reset_floor got %0d want 0", car_floor); end
    n_tests++; if (door_closed !== 1'b1 || door_fully_open !== 1'b0) begin n_fail++; $display("FAIL reset_door got closed=%b open=%b want 1/0", door_closed, door_fully_open); end
    n_tests++; if (fault !== 1'b0 || fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_fault got %b/%b want 0/00", fault, fault_code); end
    n_tests++; if (moving_up !== 1'b0 || moving_down !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %b%b want 00", moving_up, moving_down); end
  endtask

  task automatic test_travel_up();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0000 || moving_up !== 1'b1) begin n_fail++; $display("FAIL travel_edge1 got sensor=%b mu=%b want 0000/1", floor_sensor, moving_up); end
    run(TC - 2, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0000) begin n_fail++; $display("FAIL travel_edge15 got %b want 0000", floor_sensor); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0010 || car_floor !== 2'd1) begin n_fail++; $display("FAIL travel_edge16 got sensor=%b floor=%0d want 0010/1", floor_sensor, car_floor); end
    run(3, 1'b0, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0010 || moving_up !== 1'b0) begin n_fail++; $display("FAIL travel_hold got sensor=%b mu=%b want 0010/0", floor_sensor, moving_up); end
  endtask

  task automatic test_door();
    run(DC - 1, 1'b0, 1'b0, 1'b1);
    n_tests++; if (door_fully_open !== 1'b0 || door_closed !== 1'b0) begin n_fail++; $display("FAIL door_edge7 got open=%b closed=%b want 0/0", door_fully_open, door_closed); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (door_fully_open !== 1'b1) begin n_fail++; $display("FAIL door_edge8 got %b want 1", door_fully_open); end
    run(2, 1'b0, 1'b0, 1'b1);
    n_tests++; if (door_fully_open !== 1'b1) begin n_fail++; $display("FAIL door_saturate got %b want 1", door_fully_open); end
    run(DC - 1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (door_closed !== 1'b0 || door_fully_open !== 1'b0) begin n_fail++; $display("FAIL door_close7 got closed=%b open=%b want 0/0", door_closed, door_fully_open); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (door_closed !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL door_close8 got closed=%b fault=%b want 1/0", door_closed, fault); end
  endtask

  task automatic test_door_fault();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(TC, 1'b1, 1'b0, 1'b0);
    run(4, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (fault !== 1'b1 || fault_code !== 2'b10) begin n_fail++; $display("FAIL doorfault_code got %b/%b want 1/10", fault, fault_code); end
    n_tests++; if (floor_sensor !== 4'b0010 || moving_down !== 1'b0) begin n_fail++; $display("FAIL doorfault_pos got sensor=%b md=%b want 0010/0", floor_sensor, moving_down); end
    run(3, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0010 || moving_up !== 1'b0 || fault_code !== 2'b10) begin n_fail++; $display("FAIL doorfault_ignore got sensor=%b mu=%b code=%b want 0010/0/10", floor_sensor, moving_up, fault_code); end
    n_tests++; if (door_closed !== 1'b1) begin n_fail++; $display("FAIL doorfault_rescue got closed=%b want 1", door_closed); end
  endtask

  task automatic test_both_motors();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (fault !== 1'b1 || fault_code !== 2'b01 || floor_sensor !== 4'b0001) begin n_fail++; $display("FAIL both_motors got fault=%b code=%b sensor=%b want 1/01/0001", fault, fault_code, floor_sensor); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (fault_code !== 2'b01) begin n_fail++; $display("FAIL first_code_kept got %b want 01", fault_code); end
  endtask

  task automatic test_overtravel();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(3 * TC, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b1000 || car_floor !== 2'd3 || fault !== 1'b0) begin n_fail++; $display("FAIL top_floor got sensor=%b floor=%0d fault=%b want 1000/3/0", floor_sensor, car_floor, fault); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (fault !== 1'b1 || fault_code !== 2'b11 || floor_sensor !== 4'b1000) begin n_fail++; $display("FAIL overtravel_top got fault=%b code=%b sensor=%b want 1/11/1000", fault, fault_code, floor_sensor); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (fault_code !== 2'b11 || floor_sensor !== 4'b0001) begin n_fail++; $display("FAIL overtravel_bottom got code=%b sensor=%b want 11/0001", fault_code, floor_sensor); end
  endtask

  task automatic test_sensor_mask();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(TC, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    sensor_mask = 4'b1101;
    #1;
    n_tests++; if (floor_sensor !== 4'b0000 || car_floor !== 2'd1) begin n_fail++; $display("FAIL mask_bit1 got sensor=%b floor=%0d want 0000/1", floor_sensor, car_floor); end
    run(2, 1'b0, 1'b0, 1'b1);
    n_tests++; if (door_closed !== 1'b0) begin n_fail++; $display("FAIL mask_door_opens got closed=%b want 0", door_closed); end
    sensor_mask = 4'hF;
    run(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++; if (moving_up !== 1'b1 || door_closed !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL move_and_door got mu=%b closed=%b fault=%b want 1/1/0", moving_up, door_closed, fault); end
    run(4, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b1);
    n_tests++; if (door_closed !== 1'b1 || fault !== 1'b0 || floor_sensor !== 4'b0000) begin n_fail++; $display("FAIL unaligned_door got closed=%b fault=%b sensor=%b want 1/0/0000", door_closed, fault, floor_sensor); end
  endtask

  task automatic test_midtravel_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(7, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (fault !== 1'b1 || floor_sensor !== 4'b0000 || car_floor !== 2'd0) begin n_fail++; $display("FAIL mid_fault got fault=%b sensor=%b floor=%0d want 1/0000/0", fault, floor_sensor, car_floor); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++; if (floor_sensor !== 4'b0001 || fault !== 1'b0 || door_closed !== 1'b1 || fault_code !== 2'b00) begin n_fail++; $display("FAIL mid_reset got sensor=%b fault=%b closed=%b code=%b want 0001/0/1/00", floor_sensor, fault, door_closed, fault_code); end
  endtask

  task automatic test_random();
    logic [13:0] act, exp;
    int          r;
    bit          up, dn, dop;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) sensor_mask = 4'($urandom_range(0, 15));
      if (m_fault && $urandom_range(0, 7) == 0) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        r   = $urandom_range(0, 99);
        up  = (r < 35) || (r == 99);
        dn  = (r >= 35 && r < 60) || (r == 99);
        dop = $urandom_range(0, 1) == 1;
        cycle(1'b0, up, dn, dop);
      end
      act = {floor_sensor, car_floor, moving_up, moving_down, door_closed, door_fully_open, fault, fault_code};
      exp = expected_outputs();
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d got %b want %b (sens,flr,mu,md,closed,open,fault,code)", i, act, exp);
      end
    end
    sensor_mask = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_pos = 0; m_dpos = 0; m_code = 0; m_fault = 0; m_mu = 0; m_md = 0;
    @(negedge clk);
    test_reset();
    test_travel_up();
    test_door();
    test_door_fault();
    test_both_motors();
    test_overtravel();
    test_sensor_mask();
    test_simultaneous();
    test_midtravel_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_shaft_model.md
Name: elevator_shaft_model

Overview:
- Behavioural plant model of a 4-floor car and shaft. It is the other end of the motor/door/floor-sensor interface driven by the elevator controller.
- Consumes motor_up, motor_down and door_open commands. Produces one-hot floor_sensor, door position status and fault flags.
- Closes the loop for system simulation and FPGA demo boards. Includes a sensor-mask input for fault injection.

Parameters:
- TRAVEL_CYCLES, 16: clock cycles of motor drive to move exactly one floor (>=2).
- DOOR_CYCLES, 8: clock cycles for the door to travel fully closed to fully open (>=1).
- INIT_FLOOR, 0: floor (0..3) at which the car is aligned after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- motor_up  in  1  drive car upward one step per cycle
- motor_down  in  1  drive car downward one step per cycle
- door_open  in  1  1 = open door, 0 = close door
- sensor_mask  in  4  per-floor sensor enable; 0 forces that sensor bit low (fault injection)
- floor_sensor  out  4  one-hot; bit f high only while the car is exactly aligned at floor f
- car_floor  out  2  floor at or immediately below the car
- moving_up  out  1  car moved up on the last edge
- moving_down  out  1  car moved down on the last edge
- door_closed  out  1  door position == 0
- door_fully_open  out  1  door position == DOOR_CYCLES
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 both motors, 10 motion with door not closed, 11 overtravel

Behaviour:
- State and counters:
  - pos: car position counter, 0..3*TRAVEL_CYCLES. Aligned at floor f when pos == f*TRAVEL_CYCLES.
  - dpos: door position counter, 0..DOOR_CYCLES.
  - Car FSM: IDLE, MOVE_UP, MOVE_DOWN, FAULT.
- Reset (synchronous):
  - pos = INIT_FLOOR*TRAVEL_CYCLES, dpos = 0, FSM = IDLE.
  - fault = 0, fault_code = 00, moving_up = moving_down = 0.
  - Hence floor_sensor = one-hot(INIT_FLOOR) & sensor_mask, car_floor = INIT_FLOOR, door_closed = 1, door_fully_open = 0.
  - Reset asserted mid-travel or in FAULT restores this state on that edge.
- Decoded outputs: floor_sensor, car_floor, door_closed and door_fully_open are combinational decodes of the registered pos and dpos. They reflect an update in the cycle after the edge that made it.
- Motion, evaluated each edge when not in FAULT, in priority order:
  1. motor_up & motor_down: enter FAULT, code 01, pos unchanged.
  2. Any motor input high while dpos != 0: enter FAULT, code 10, pos unchanged.
  3. motor_up at pos == 3*TRAVEL_CYCLES, or motor_down at pos == 0: enter FAULT, code 11, pos unchanged.
  4. motor_up: pos += 1, state MOVE_UP, moving_up = 1.
  5. motor_down: pos -= 1, state MOVE_DOWN, moving_down = 1.
  6. Neither motor input: state IDLE, moving_* = 0.
- Motion has no inertia. The car stops on the first edge with no motor input, including between floors, where floor_sensor = 0000.
- FAULT:
  - pos is frozen, moving_* = 0, and motor inputs are ignored.
  - fault and fault_code hold until reset.
  - The first-detected code is kept; later violations do not overwrite it.
- Door, evaluated each edge:
  - If door_open = 1, the car is aligned (ignores sensor_mask), no motor input is high and dpos < DOOR_CYCLES: dpos += 1.
  - If door_open = 0 and dpos > 0: dpos -= 1.
  - door_open while unaligned or while a motor input is high: dpos holds, no fault.
  - The door continues to operate in FAULT (rescue).
  - dpos saturates at both ends.
- Simultaneous events:
  - Motor and door_open on the same edge with dpos == 0: the car moves and the door does not open.
  - Fault detection uses dpos before that edge's door update.

Test Plan:
- Reset with INIT_FLOOR=0, default params -> floor_sensor=0001, car_floor=0, door_closed=1, fault=0.
- motor_up held from cycle 0 -> floor_sensor=0000 after edge 1; 0010 after edge 16; car_floor=1. Release motor_up -> pos holds, sensor stays 0010.
- At floor 1, door_open=1 for 10 cycles -> door_fully_open=1 after edge 8 and holds. door_open=0 -> door_closed=1 after 8 more edges.
- Door half open (dpos=4), assert motor_down -> fault=1, code=10, pos unchanged; later motor_up still ignored.
- motor_up=motor_down=1 at floor 0 -> code 01. Separately, after reset at floor 3, motor_up -> code 11. With sensor_mask=1101 at floor 1 -> floor_sensor=0000 while car_floor=1.
- Reset asserted mid-travel (pos=7, fault present) -> next cycle floor_sensor=0001, fault=0, door_closed=1.
